// File: rtl/traffic_conflict_monitor_if.sv
// Light-code / lamp-drive bundle between the traffic light controller,
// the conflict monitor and the lamp drivers.
// master: the controller side (drives light codes and operator clear).
// slave : the monitor (drives lamps and fault status).
interface traffic_conflict_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_M2;
  logic [2:0] light_MT;
  logic [2:0] light_S;
  logic       fault_clr;
  logic [2:0] lamp_M1;
  logic [2:0] lamp_M2;
  logic [2:0] lamp_MT;
  logic [2:0] lamp_S;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output light_M1, light_M2, light_MT, light_S, fault_clr,
    input  lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code
  );

  modport slave (
    input  light_M1, light_M2, light_MT, light_S, fault_clr,
    output lamp_M1, lamp_M2, lamp_MT, lamp_S, fault, fault_code
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Traffic light conflict monitor.
// Registers the controller's four light codes, rejects illegal encodings,
// conflicting right-of-way and (optionally) a stalled controller, and drives
// a flashing-red failsafe until an operator clear plus an all-red interval.
// Build option: define MONITOR_WDOG_EN to include the stalled-input watchdog
// (fault_code 3). Without it the watchdog logic is not built.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | legal patterns forwarded to lamps, violations filtered
// ST_FAULT   | fault latched, lamps flash red/off, waiting for operator clear
// ST_RECOVER | all-red interval before resuming RUN (also the reset state)
module traffic_conflict_monitor #(
  parameter int CONFLICT_FILT = 1,
  parameter int FLASH_HALF    = 4,
  parameter int ALLRED_CYC    = 3,
  parameter int WDOG_MAX      = 16
) (
  input logic                       clk,
  input logic                       rst,
  traffic_conflict_monitor_if.slave bus
);

  localparam logic [11:0] ALL_RED = {4{3'b100}};
  localparam int RW = $clog2(ALLRED_CYC);
  localparam int FW = $clog2(FLASH_HALF + 1);

  if (CONFLICT_FILT < 1 || CONFLICT_FILT > 15 || FLASH_HALF < 1 ||
      ALLRED_CYC < 2 || WDOG_MAX < 2) begin : g_param_check
    $error("traffic_conflict_monitor: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FAULT   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [11:0]     in_q, in_d;
  logic [11:0]     lamps_q, lamps_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      filt_q, filt_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;

  logic            v_enc, v_conf, v_wdog, legal;
  logic [1:0]      cause;

  // Field order inside the packed words: {M1, M2, MT, S}.
  assign in_d = {bus.light_M1, bus.light_M2, bus.light_MT, bus.light_S};

  function automatic logic onehot3(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

  function automatic logic go3(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010);
  endfunction

  // Legality checks on the registered pattern and cause priority enc > conf > wdog.
  always_comb begin
    v_enc  = !(onehot3(in_q[11:9]) && onehot3(in_q[8:6]) &&
               onehot3(in_q[5:3])  && onehot3(in_q[2:0]));
    v_conf = (go3(in_q[2:0]) && (go3(in_q[11:9]) || go3(in_q[8:6]) || go3(in_q[5:3]))) ||
             (go3(in_q[8:6]) && go3(in_q[5:3]));
    legal  = !v_enc && !v_conf;
    if (v_enc)       cause = 2'd1;
    else if (v_conf) cause = 2'd2;
    else if (v_wdog) cause = 2'd3;
    else             cause = 2'd0;
  end

`ifdef MONITOR_WDOG_EN
  localparam int HW = $clog2(WDOG_MAX + 1);
  logic [HW-1:0] hold_q, hold_d;

  // Hold counter register for the stalled-controller watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_q <= '0;
    else      hold_q <= hold_d;
  end

  // Count consecutive RUN edges that leave the sampled pattern unchanged.
  always_comb begin
    hold_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && in_d == in_q)
      hold_d = (hold_q == HW'(WDOG_MAX)) ? hold_q : hold_q + 1'b1;
  end

  assign v_wdog = (hold_q == HW'(WDOG_MAX));
`else
  assign v_wdog = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RECOVER;
      in_q    <= ALL_RED;
      lamps_q <= ALL_RED;
      rcnt_q  <= '0;
      fcnt_q  <= '0;
      phase_q <= 1'b1;
      filt_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      lamps_q <= lamps_d;
      rcnt_q  <= rcnt_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      filt_q  <= filt_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  // Next-state: filter, flash timing, clear handling and the all-red interval.
  always_comb begin
    state_d = state_q;
    rcnt_d  = '0;
    fcnt_d  = '0;
    phase_d = 1'b1;
    filt_d  = '0;
    case (state_q)
      ST_RUN: begin
        if (cause != 2'd0) begin
          if (filt_q == 4'(CONFLICT_FILT - 1)) state_d = ST_FAULT;
          else                                 filt_d  = filt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr && legal) begin
          state_d = ST_RECOVER;
        end else if (fcnt_q == FW'(FLASH_HALF - 1)) begin
          phase_d = !phase_q;
        end else begin
          fcnt_d  = fcnt_q + 1'b1;
          phase_d = phase_q;
        end
      end
      ST_RECOVER: begin
        if (rcnt_q == RW'(ALLRED_CYC - 1)) state_d = legal ? ST_RUN : ST_FAULT;
        else                               rcnt_d  = rcnt_q + 1'b1;
      end
      default: state_d = ST_RECOVER;
    endcase
  end

  // Outputs for the coming cycle: lamp pattern, fault flag and latched cause.
  always_comb begin
    lamps_d = ALL_RED;
    fault_d = 1'b0;
    code_d  = 2'd0;
    case (state_d)
      ST_RUN: begin
        // A filtered violation freezes the last legal pattern on the lamps.
        lamps_d = (state_q == ST_RUN && cause != 2'd0) ? lamps_q : in_q;
      end
      ST_FAULT: begin
        fault_d = 1'b1;
        lamps_d = phase_d ? ALL_RED : 12'd0;
        code_d  = (state_q == ST_FAULT) ? code_q : cause;
      end
      default: ;
    endcase
  end

  assign bus.lamp_M1    = lamps_q[11:9];
  assign bus.lamp_M2    = lamps_q[8:6];
  assign bus.lamp_MT    = lamps_q[5:3];
  assign bus.lamp_S     = lamps_q[2:0];
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Sits directly downstream of the traffic light controller FSM, between its four light-code outputs and the physical lamp drivers.
- Registers the four light codes and checks every cycle for illegal encodings, conflicting right-of-way and a stalled controller.
- Forwards only legal patterns to the lamps. On any violation it latches a fault and drives a flashing-red failsafe until an operator clear is followed by an all-red recovery interval.

Parameters:
- CONFLICT_FILT, 1: consecutive cycles a violation must persist before a fault is declared (1..15).
- FLASH_HALF, 4: cycles per half-period of the failsafe flash (>=1).
- ALLRED_CYC, 3: length of the all-red RECOVER interval, in cycles (>=2).
- WDOG_MAX, 16: consecutive cycles of unchanged input that trip the watchdog (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- light_M1  in  3  controller code, main road 1. 001=green, 010=yellow, 100=red.
- light_M2  in  3  controller code, main road 2.
- light_MT  in  3  controller code, main turn.
- light_S  in  3  controller code, side road.
- fault_clr  in  1  operator clear, level-sampled.
- lamp_M1  out  3  registered lamp drive, same encoding as the inputs.
- lamp_M2  out  3  lamp drive.
- lamp_MT  out  3  lamp drive.
- lamp_S  out  3  lamp drive.
- fault  out  1  high while in FAULT.
- fault_code  out  2  0=none, 1=bad encoding, 2=conflict, 3=watchdog.

Behaviour:
- Reset (rst=0): state=RECOVER, recovery counter=0, every lamp_*=100, fault=0, fault_code=0, flash phase=on, filter and hold counters=0, input regs in_q=100 each.
- Every rising edge: in_q <= the four light inputs. All checks below operate on in_q.
- V_enc: any in_q field is not exactly one-hot.
- V_conf: the field is non-red (green or yellow) for S together with any of M1/M2/MT, or for M2 and MT together.
- Cause priority when more than one check fires: enc > conf > watchdog.
- RUN, no violation: lamps <= in_q, so lamps lag the controller by 2 edges. Filter count resets to 0.
- RUN, violation present: filter count increments and lamps hold their last legal value. An illegal pattern never reaches the lamps.
  - When the filter count reaches CONFLICT_FILT → FAULT, fault=1, fault_code latches the highest-priority cause, lamps <= all 100 on that same edge.
- FAULT:
  - Flash counter runs continuously. Phase toggles every FLASH_HALF cycles; the first phase is on, starting at the entry edge.
  - Lamps are all 100 in the on phase and all 000 in the off phase.
  - fault_clr=1 at an edge with in_q legal → RECOVER. If in_q is illegal, fault_clr is ignored.
  - New violations in FAULT do not overwrite fault_code.
- RECOVER: lamps all 100, fault=0, fault_code=0.
  - Counter runs 0..ALLRED_CYC-1.
  - At the edge where counter=ALLRED_CYC-1: if in_q is legal, → RUN and lamps <= in_q; otherwise → FAULT with code per the checks above.
- Watchdog: hold counter runs only in RUN and is cleared on any in_q change or on RUN entry.
  - When in_q has been identical for WDOG_MAX consecutive edges, it is treated as a violation (code 3) and goes through the same filter path.
- fault_clr held high continuously: exits FAULT only once, on the first qualifying edge. It has no effect in RUN or RECOVER.
- Reset asserted mid-FAULT or mid-RECOVER: immediate return to the reset values above.
- No handshake: inputs are sampled every cycle.

Optional Feature:
- Macro: MONITOR_WDOG_EN.
- Defined: the watchdog is built and fault_code=3 is reachable.
- Undefined: the hold counter and WDOG_MAX logic are removed, a stalled but legal input stays in RUN indefinitely, and fault_code never reads 3.

Test Plan:
- Reset release with a legal pattern (M1=001, M2=001, MT=100, S=100) held → lamps all 100 after edges 1-2, and lamps equal the pattern from edge 3 onward; fault=0.
- In RUN, drive S=001 while M1=001 for one cycle (filter=1) → the FAULT entry edge sets fault=1, fault_code=2, lamps 100. The conflicting pattern never appears on the lamps, and lamps then alternate 100/000 every 4 cycles.
- Drive M2=011 → fault_code=1. Drive M2=011 and S=001 together → fault_code=1, confirming encoding priority.
- In FAULT with legal inputs, pulse fault_clr=1 for one cycle → fault=0 and code=0 at that edge, lamps 100 for 3 cycles, then lamps follow the inputs.
- With MONITOR_WDOG_EN defined, hold a legal pattern for 16 cycles → fault_code=3. Without the macro, hold it for 100 cycles → fault stays 0.
- Assert rst mid-flash with lamps 000 → lamps immediately 100, fault=0, fault_code=0.
